// File: rtl/foo_intf_arbiter_if.sv
// foo_intf_arbiter_if
// Bundles the requester-side and sink-side signals of the round-robin arbiter.
//   req       : per-requester beat request, bit i belongs to requester i
//   last      : per-requester final-beat flag, only meaningful with req
//   wdata     : requester i's beat lives in slice [i*DW +: DW]
//   gnt       : one-hot (or zero) registered grant
//   out_valid : forwarded beat valid
//   out_data  : forwarded beat, holds its value when out_valid is low
//   out_src   : index of the requester that produced out_data
// Modports: master = requesters plus sink (drives requests, observes grant and
// output); slave = the arbiter itself.

interface foo_intf_arbiter_if #(
    parameter int N  = 4,
    parameter int DW = 8
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]    req;
    logic [N-1:0]    last;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    gnt;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [IW-1:0]   out_src;

    modport master (
        output req, last, wdata,
        input  gnt, out_valid, out_data, out_src
    );

    modport slave (
        input  req, last, wdata,
        output gnt, out_valid, out_data, out_src
    );
endinterface

// File: rtl/foo_intf_arbiter.sv
// foo_intf_arbiter
// Round-robin arbiter sharing one single-beat downstream channel among N
// requesters. One requester owns the channel at a time; its beats are forwarded
// with one cycle of latency and a tenure ends on a last beat, on the MAX_HOLD-th
// beat, or when the owner drops req. One IDLE cycle separates tenures.
//
// Ports:
//   clk : single clock, all state on the rising edge
//   rst : asynchronous active-high reset
//   bus : foo_intf_arbiter_if.slave (req/last/wdata in, gnt/out_* out)
//
// State table
//   state    | meaning
//   ST_IDLE  | no owner; gnt is zero; pick next requester searching up from ptr
//   ST_GRANT | owner holds the channel; beats accepted whenever req[owner]=1

module foo_intf_arbiter #(
    parameter int N        = 4,
    parameter int DW       = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    foo_intf_arbiter_if.slave bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(MAX_HOLD + 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [CW-1:0] beat_cnt_q, beat_cnt_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [IW-1:0] out_src_q, out_src_d;

    logic [IW-1:0] pick;
    logic          pick_vld;
    logic [IW-1:0] idx;
    logic          own_req;
    logic          own_last;
    logic [DW-1:0] own_data;
    logic [IW-1:0] owner_inc;
    logic          hold_limit;
    logic          release_now;

    // Round-robin search: walk from the farthest candidate back toward ptr so
    // the nearest requesting index (starting at ptr, wrapping) is written last.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        idx      = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr_q) + k) % N);
            if (bus.req[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

    // Owner's request, last flag and data beat, selected by a constant-index mux.
    always_comb begin
        own_req  = 1'b0;
        own_last = 1'b0;
        own_data = '0;
        for (int i = 0; i < N; i++) begin
            if (owner_q == IW'(i)) begin
                own_req  = bus.req[i];
                own_last = bus.last[i];
                own_data = bus.wdata[i*DW +: DW];
            end
        end
    end

    assign owner_inc  = (owner_q == IW'(N - 1)) ? '0 : owner_q + IW'(1);
    assign hold_limit = (beat_cnt_q == CW'(MAX_HOLD - 1));

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        beat_cnt_d  = beat_cnt_q;
        gnt_d       = gnt_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        release_now = 1'b0;

        case (state_q)
            ST_IDLE: begin
                gnt_d = '0;
                if (pick_vld) begin
                    owner_d     = pick;
                    beat_cnt_d  = '0;
                    gnt_d[pick] = 1'b1;
                    state_d     = ST_GRANT;
                end
            end

            ST_GRANT: begin
                if (own_req) begin
                    out_valid_d = 1'b1;
                    out_data_d  = own_data;
                    out_src_d   = owner_q;
                    beat_cnt_d  = beat_cnt_q + CW'(1);
                    // last and hold limit in the same beat collapse into one release
                    release_now = own_last | hold_limit;
                end else begin
                    // owner abandoned the tenure; nothing accepted this cycle
                    release_now = 1'b1;
                end

                if (release_now) begin
                    state_d = ST_IDLE;
                    ptr_d   = owner_inc;
                    gnt_d   = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            beat_cnt_q  <= '0;
            gnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            beat_cnt_q  <= beat_cnt_d;
            gnt_q       <= gnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;

endmodule
